// File: rtl/udc_pkg.sv
// Shared definitions for the up/down counter configuration sequencer.
// Register addresses, fail codes, FSM states and config field layout.
package udc_pkg;

    localparam logic [1:0] PLR_A = 2'd0;
    localparam logic [1:0] ULR_A = 2'd1;
    localparam logic [1:0] LLR_A = 2'd2;
    localparam logic [1:0] CCR_A = 2'd3;

    localparam logic [1:0] FC_PRECHECK = 2'd0;
    localparam logic [1:0] FC_READBACK = 2'd1;
    localparam logic [1:0] FC_CNT_ERR  = 2'd2;
    localparam logic [1:0] FC_TIMEOUT  = 2'd3;

    localparam int unsigned PLR_LSB = 0;
    localparam int unsigned ULR_LSB = 8;
    localparam int unsigned LLR_LSB = 16;
    localparam int unsigned CCR_LSB = 24;

    typedef enum logic [3:0] {
        StIdle,
        StGrant,
        StCrst,
        StWrite,
        StRead,
        StCheck,
        StStart,
        StRun,
        StDone,
        StFail
    } state_e;

    function automatic logic [7:0] cfg_field(input logic [31:0] cfg, input logic [1:0] addr);
        logic [7:0] f;
        case (addr)
            PLR_A:   f = cfg[PLR_LSB +: 8];
            ULR_A:   f = cfg[ULR_LSB +: 8];
            LLR_A:   f = cfg[LLR_LSB +: 8];
            default: f = cfg[CCR_LSB +: 8];
        endcase
        return f;
    endfunction

    // A config is only worth loading if the preload lies within the limits
    // and the cycle count is non-zero.
    function automatic logic precheck_ok(input logic [31:0] cfg);
        return (cfg[LLR_LSB +: 8] <= cfg[PLR_LSB +: 8]) &&
               (cfg[PLR_LSB +: 8] <= cfg[ULR_LSB +: 8]) &&
               (cfg[CCR_LSB +: 8] != 8'd0);
    endfunction

endpackage

// File: rtl/udc_rr_arb2.sv
// Two-requester round-robin arbiter. The last-winner pointer only moves on
// the update strobe, so the grant stays stable for a whole session.
module udc_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       upd_idx_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);

    logic last_q;

    // Reset value 1 makes requester 0 win the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (upd_i) begin
            last_q <= upd_idx_i;
        end
    end

    always_comb begin
        gnt_idx_o = (req_i == 2'b11) ? ~last_q : req_i[1];
        gnt_o     = 2'b00;
        if (req_i != 2'b00) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/udc_cfg_sequencer.sv
// Bus-master sequencer: grants one of two requesters, loads and verifies the
// counter registers, starts a count cycle and reports done or fail.
module udc_cfg_sequencer
    import udc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned GAP     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] cfg0,
    input  logic [31:0] cfg1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [1:0]  fail,
    output logic [1:0]  fail_code,
    output logic        busy,
    output logic        cnt_rst_n,
    output logic        cnt_ncs,
    output logic        cnt_nwr,
    output logic        cnt_nrd,
    output logic [1:0]  cnt_a,
    output logic [7:0]  cnt_dout,
    output logic        cnt_oe,
    input  logic [7:0]  cnt_din,
    output logic        cnt_start,
    input  logic        cnt_err,
    input  logic        cnt_ec
);

    localparam int unsigned   TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
    localparam logic [2:0]    WrLast    = 3'(GAP);
    localparam logic [2:0]    RdLast    = 3'(GAP + 1);

    state_e        state_q;
    logic [1:0]    gnt_q;
    logic [1:0]    done_q;
    logic [1:0]    fail_q;
    logic [1:0]    fail_code_q;
    logic          busy_q;
    logic          rst_n_q;
    logic          ncs_q;
    logic          nwr_q;
    logic          nrd_q;
    logic [1:0]    a_q;
    logic [7:0]    dout_q;
    logic          oe_q;
    logic          start_q;
    logic [31:0]   shadow_q;
    logic          widx_q;
    logic [2:0]    phase_q;
    logic [TW-1:0] timer_q;

    logic [1:0]    arb_gnt;
    logic          arb_idx;
    logic          arb_upd;

    logic          fin_done;
    logic          fin_fail;
    logic [1:0]    fin_code;

    assign arb_upd = (state_q == StDone) || (state_q == StFail);

    udc_rr_arb2 u_arb (
        .clk_i     (clk),
        .rst_ni    (reset),
        .req_i     (req),
        .upd_i     (arb_upd),
        .upd_idx_i (widx_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    // Session-ending conditions; they override the normal progression below.
    always_comb begin
        fin_done = 1'b0;
        fin_fail = 1'b0;
        fin_code = FC_PRECHECK;
        unique case (state_q)
            StGrant: begin
                if (!precheck_ok(shadow_q)) begin
                    fin_fail = 1'b1;
                end
            end
            StRead: begin
                if ((phase_q == 3'd1) && (cnt_din != cfg_field(shadow_q, a_q))) begin
                    fin_fail = 1'b1;
                    fin_code = FC_READBACK;
                end
            end
            StCheck: begin
                if (cnt_err) begin
                    fin_fail = 1'b1;
                    fin_code = FC_CNT_ERR;
                end
            end
            StRun: begin
                if (cnt_ec) begin
                    fin_done = 1'b1;
                end else if (cnt_err) begin
                    fin_fail = 1'b1;
                    fin_code = FC_CNT_ERR;
                end else if (timer_q == TimerLast) begin
                    fin_fail = 1'b1;
                    fin_code = FC_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            fail_q      <= 2'b00;
            fail_code_q <= FC_PRECHECK;
            busy_q      <= 1'b0;
            rst_n_q     <= 1'b1;
            ncs_q       <= 1'b1;
            nwr_q       <= 1'b1;
            nrd_q       <= 1'b1;
            a_q         <= PLR_A;
            dout_q      <= 8'd0;
            oe_q        <= 1'b0;
            start_q     <= 1'b0;
            shadow_q    <= 32'd0;
            widx_q      <= 1'b0;
            phase_q     <= 3'd0;
            timer_q     <= '0;
        end else begin
            done_q  <= 2'b00;
            fail_q  <= 2'b00;
            start_q <= 1'b0;
            rst_n_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        state_q  <= StGrant;
                        gnt_q    <= arb_gnt;
                        widx_q   <= arb_idx;
                        busy_q   <= 1'b1;
                        shadow_q <= arb_idx ? cfg1 : cfg0;
                    end
                end
                StGrant: begin
                    state_q <= StCrst;
                    rst_n_q <= 1'b0;
                    ncs_q   <= 1'b0;
                end
                StCrst: begin
                    state_q <= StWrite;
                    phase_q <= 3'd0;
                    a_q     <= PLR_A;
                    dout_q  <= cfg_field(shadow_q, PLR_A);
                    nwr_q   <= 1'b0;
                    oe_q    <= 1'b1;
                end
                StWrite: begin
                    // Phase 0 is the strobe cycle, phases 1..GAP are bus idle.
                    if (phase_q != WrLast) begin
                        phase_q <= phase_q + 3'd1;
                        nwr_q   <= 1'b1;
                        oe_q    <= 1'b0;
                    end else if (a_q == CCR_A) begin
                        state_q <= StRead;
                        phase_q <= 3'd0;
                        a_q     <= PLR_A;
                        dout_q  <= 8'd0;
                        nrd_q   <= 1'b0;
                    end else begin
                        phase_q <= 3'd0;
                        a_q     <= a_q + 2'd1;
                        dout_q  <= cfg_field(shadow_q, a_q + 2'd1);
                        nwr_q   <= 1'b0;
                        oe_q    <= 1'b1;
                    end
                end
                StRead: begin
                    // Phases 0..1 hold the read strobe, 2..GAP+1 are bus idle.
                    if (phase_q == 3'd1) begin
                        nrd_q   <= 1'b1;
                        phase_q <= 3'd2;
                    end else if (phase_q != RdLast) begin
                        phase_q <= phase_q + 3'd1;
                    end else if (a_q == CCR_A) begin
                        state_q <= StCheck;
                    end else begin
                        a_q     <= a_q + 2'd1;
                        nrd_q   <= 1'b0;
                        phase_q <= 3'd0;
                    end
                end
                StCheck: begin
                    state_q <= StStart;
                    start_q <= 1'b1;
                end
                StStart: begin
                    state_q <= StRun;
                    timer_q <= '0;
                end
                StRun: begin
                    timer_q <= timer_q + TW'(1);
                end
                StDone, StFail: begin
                    state_q     <= StIdle;
                    gnt_q       <= 2'b00;
                    busy_q      <= 1'b0;
                    fail_code_q <= FC_PRECHECK;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (fin_done || fin_fail) begin
                state_q     <= fin_done ? StDone : StFail;
                done_q      <= fin_done ? gnt_q : 2'b00;
                fail_q      <= fin_fail ? gnt_q : 2'b00;
                fail_code_q <= fin_code;
                rst_n_q     <= 1'b1;
                ncs_q       <= 1'b1;
                nwr_q       <= 1'b1;
                nrd_q       <= 1'b1;
                oe_q        <= 1'b0;
                a_q         <= PLR_A;
                dout_q      <= 8'd0;
                start_q     <= 1'b0;
            end
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign busy      = busy_q;
    assign cnt_rst_n = rst_n_q;
    assign cnt_ncs   = ncs_q;
    assign cnt_nwr   = nwr_q;
    assign cnt_nrd   = nrd_q;
    assign cnt_a     = a_q;
    assign cnt_dout  = dout_q;
    assign cnt_oe    = oe_q;
    assign cnt_start = start_q;

endmodule

// File: tb/tb_udc_cfg_sequencer.sv
// Scoreboard bench for udc_cfg_sequencer: directed sessions push expected bus
// events, a negedge monitor pops and compares what the DUT actually drives.
module tb_udc_cfg_sequencer;

    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned GAP     = 2;

    localparam int EvW = 0;
    localparam int EvR = 1;
    localparam int EvS = 2;
    localparam int EvD = 3;
    localparam int EvF = 4;

    localparam logic [31:0] CfgA   = 32'h020A140F;  // ccr=2 llr=10 ulr=20 plr=15
    localparam logic [31:0] CfgB   = 32'h0100FF80;  // ccr=1 llr=0 ulr=255 plr=128
    localparam logic [31:0] CfgBad = 32'h020A1405;  // plr=5 below llr=10

    localparam logic [24:0] RstVec = {2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1,
                                      1'b1, 2'b00, 8'h00, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] cfg0;
    logic [31:0] cfg1;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  fail;
    logic [1:0]  fail_code;
    logic        busy;
    logic        cnt_rst_n;
    logic        cnt_ncs;
    logic        cnt_nwr;
    logic        cnt_nrd;
    logic [1:0]  cnt_a;
    logic [7:0]  cnt_dout;
    logic        cnt_oe;
    logic [7:0]  cnt_din;
    logic        cnt_start;
    logic        cnt_err;
    logic        cnt_ec;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;
        int idx;
        int data;
    } ev_t;
    ev_t exp_q[$];

    logic [7:0] regs [4];
    bit         bad_ulr = 1'b0;
    bit         ec_mode = 1'b1;
    bit         ncs_low_seen = 1'b0;

    udc_cfg_sequencer #(
        .TIMEOUT (TIMEOUT),
        .GAP     (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .cfg0      (cfg0),
        .cfg1      (cfg1),
        .gnt       (gnt),
        .done      (done),
        .fail      (fail),
        .fail_code (fail_code),
        .busy      (busy),
        .cnt_rst_n (cnt_rst_n),
        .cnt_ncs   (cnt_ncs),
        .cnt_nwr   (cnt_nwr),
        .cnt_nrd   (cnt_nrd),
        .cnt_a     (cnt_a),
        .cnt_dout  (cnt_dout),
        .cnt_oe    (cnt_oe),
        .cnt_din   (cnt_din),
        .cnt_start (cnt_start),
        .cnt_err   (cnt_err),
        .cnt_ec    (cnt_ec)
    );

    always #5 clk = ~clk;

    // Counter register file model.
    always @(posedge clk) begin
        if (!cnt_ncs && !cnt_nwr) begin
            regs[cnt_a] <= cnt_dout;
        end
    end

    always_comb begin
        cnt_din = regs[cnt_a];
        if (bad_ulr && cnt_a == 2'd1) begin
            cnt_din = 8'hFF;
        end
    end

    // End-of-cycle model: ec pulses 40 cycles after a start pulse.
    initial begin
        cnt_ec = 1'b0;
        forever begin
            @(negedge clk);
            if (cnt_start && ec_mode) begin
                repeat (40) @(negedge clk);
                cnt_ec = 1'b1;
                @(negedge clk);
                cnt_ec = 1'b0;
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic push(input int k, input int i, input int d);
        ev_t e;
        e.kind = k;
        e.idx  = i;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_session(input logic [31:0] cfg, input int who, input int nreads,
                                input bit with_start, input int kind, input int code);
        for (int a = 0; a < 4; a++) push(EvW, a, int'(cfg[8*a +: 8]));
        for (int a = 0; a < nreads; a++) push(EvR, a, 0);
        if (with_start) push(EvS, 0, 0);
        push(kind, who, code);
    endtask

    task automatic observe(input int k, input int i, input int d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got kind=%0d idx=%0d data=%0d, required no event (t=%0t)",
                     k, i, d, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.idx != i || e.data != d) begin
                errors++;
                $display("FAIL scoreboard: got kind=%0d idx=%0d data=%0d, required kind=%0d idx=%0d data=%0d (t=%0t)",
                         k, i, d, e.kind, e.idx, e.data, $time);
            end
        end
    endtask

    function automatic logic [24:0] out_vec();
        return {gnt, done, fail, fail_code, busy, cnt_rst_n, cnt_ncs, cnt_nwr, cnt_nrd,
                cnt_a, cnt_dout, cnt_oe, cnt_start};
    endfunction

    // Monitor.
    int cyc = 0;
    int last_w = 0;
    int last_r = 0;
    int nrd_len = 0;
    bit prev_nrd = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (!cnt_ncs) ncs_low_seen = 1'b1;
        check("nwr_nrd_exclusive", int'(!cnt_nwr && !cnt_nrd), 0);
        check("oe_follows_nwr", int'(cnt_oe), int'(!cnt_nwr));
        if (!cnt_nwr) begin
            observe(EvW, int'(cnt_a), int'(cnt_dout));
            if (cnt_a != 2'd0) check("write_spacing", cyc - last_w, GAP + 1);
            last_w = cyc;
        end
        if (!cnt_nrd && prev_nrd) begin
            observe(EvR, int'(cnt_a), 0);
            if (cnt_a != 2'd0) check("read_spacing", cyc - last_r, GAP + 2);
            last_r = cyc;
        end
        if (cnt_nrd && !prev_nrd) check("read_strobe_len", nrd_len, 2);
        nrd_len  = cnt_nrd ? 0 : nrd_len + 1;
        prev_nrd = cnt_nrd;
        if (cnt_start) observe(EvS, 0, 0);
        for (int i = 0; i < 2; i++) begin
            if (done[i]) observe(EvD, i, 0);
            if (fail[i]) observe(EvF, i, int'(fail_code));
        end
    end

    task automatic wait_end(input int who, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done[who] || fail[who]) && n < budget);
        if (!(done[who] || fail[who])) begin
            checks++;
            errors++;
            $display("FAIL wait_end_%0d: no done/fail after %0d cycles, required a pulse", who, n);
        end
    endtask

    task automatic release_req(input int who);
        @(negedge clk);
        check("pulse_width", int'(done[who] | fail[who]), 0);
        req[who] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_outputs", int'(out_vec()), int'(RstVec));
        reset = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        reset   = 1'b0;
        req     = 2'b00;
        cfg0    = 32'd0;
        cfg1    = 32'd0;
        cnt_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'(out_vec()), int'(RstVec));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Requester 0 alone, successful session.
        cfg0 = CfgA;
        push_session(CfgA, 0, 4, 1'b1, EvD, 0);
        req[0] = 1'b1;
        wait_end(0, 400, n);
        check("t1_gnt", int'(gnt), 1);
        check("t1_busy", int'(busy), 1);
        release_req(0);

        // Requester 1 with a config that fails precheck.
        cfg1 = CfgBad;
        push(EvF, 1, 0);
        ncs_low_seen = 1'b0;
        req[1] = 1'b1;
        wait_end(1, 20, n);
        check("t2_fail_latency", n, 2);
        check("t2_gnt", int'(gnt), 2);
        release_req(1);
        check("t2_ncs_never_low", int'(ncs_low_seen), 0);

        // Both requesting after reset: 0 then 1, and again 0 then 1.
        cfg1 = CfgB;
        pulse_reset();
        for (int round = 0; round < 2; round++) begin
            push_session(CfgA, 0, 4, 1'b1, EvD, 0);
            push_session(CfgB, 1, 4, 1'b1, EvD, 0);
            @(negedge clk);
            req = 2'b11;
            wait_end(0, 400, n);
            release_req(0);
            wait_end(1, 400, n);
            release_req(1);
        end

        // ULR readback mismatch.
        bad_ulr = 1'b1;
        push_session(CfgA, 0, 2, 1'b0, EvF, 1);
        req[0] = 1'b1;
        wait_end(0, 400, n);
        release_req(0);
        bad_ulr = 1'b0;

        // Counter error seen at CHECK.
        cnt_err = 1'b1;
        push_session(CfgB, 1, 4, 1'b0, EvF, 2);
        req[1] = 1'b1;
        wait_end(1, 400, n);
        release_req(1);
        cnt_err = 1'b0;

        // No end-of-cycle: timeout.
        ec_mode = 1'b0;
        push_session(CfgA, 0, 4, 1'b1, EvF, 3);
        req[0] = 1'b1;
        k = 0;
        while (!cnt_start && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("t6_start_seen", int'(cnt_start), 1);
        @(negedge clk);
        check("t6_start_width", int'(cnt_start), 0);
        wait_end(0, 200, n);
        check("t6_timeout_latency", n, 64);
        check("t6_ncs_released", int'(cnt_ncs), 1);
        release_req(0);
        ec_mode = 1'b1;

        // Reset during WRITE aborts; the held request restarts a fresh session.
        push(EvW, 0, int'(CfgA[7:0]));
        push(EvW, 1, int'(CfgA[15:8]));
        push_session(CfgA, 0, 4, 1'b1, EvD, 0);
        req[0] = 1'b1;
        k = 0;
        while (!(!cnt_nwr && cnt_a == 2'd1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t7_write_seen", int'(!cnt_nwr && cnt_a == 2'd1), 1);
        reset = 1'b0;
        @(negedge clk);
        check("t7_reset_outputs", int'(out_vec()), int'(RstVec));
        reset = 1'b1;
        k = 0;
        while (cnt_rst_n && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t7_crst_restart", int'(cnt_rst_n), 0);
        wait_end(0, 400, n);
        release_req(0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/udc_cfg_sequencer.md
Name: udc_cfg_sequencer

Overview:
- Bus-master controller for the 8-bit up/down counter (PLR/ULR/LLR/CCR register file; start, ec, err handshake).
- Arbitrates round-robin between two requesters, each presenting a full counter configuration.
- Per granted session: resets the counter, writes all four registers, reads them back, issues one start pulse, waits for end-of-cycle, then reports done or fail to the requester.

Parameters:
- TIMEOUT, 4096, max clk cycles in RUN before abort; sizes the run timer as clog2(TIMEOUT+1) bits.
- GAP, 1, idle cycles (ncs low, nwr/nrd high) between consecutive bus accesses; legal 1..3.

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-low
- req  in  2  per-requester request; held high until that requester's done or fail
- cfg0  in  32  requester 0 config {ccr[31:24], llr[23:16], ulr[15:8], plr[7:0]}
- cfg1  in  32  requester 1 config, same packing
- gnt  out  2  one-hot grant, high for the whole session
- done  out  2  one-cycle pulse to the granted requester on success
- fail  out  2  one-cycle pulse to the granted requester on failure
- fail_code  out  2  valid with fail: 0 precheck, 1 readback mismatch, 2 counter err, 3 timeout
- busy  out  1  high in every state except IDLE
- cnt_rst_n  out  1  counter reset, active-low
- cnt_ncs  out  1  counter chip select, active-low
- cnt_nwr  out  1  write strobe, active-low
- cnt_nrd  out  1  read strobe, active-low
- cnt_a  out  2  register address {A1,A0}: 0 PLR, 1 ULR, 2 LLR, 3 CCR
- cnt_dout  out  8  write data
- cnt_oe  out  1  tri-state enable for cnt_dout; high only while cnt_nwr low
- cnt_din  in  8  bus read data
- cnt_start  out  1  start pulse
- cnt_err  in  1  counter error flag
- cnt_ec  in  1  counter end-of-cycle flag

Behaviour:
- Reset (reset=0 at posedge): state IDLE; gnt=0, done=0, fail=0, fail_code=0, busy=0, cnt_rst_n=1, cnt_ncs=1, cnt_nwr=1, cnt_nrd=1, cnt_a=0, cnt_dout=0, cnt_oe=0, cnt_start=0; RR pointer set so requester 0 wins the first tie.
  - Reset mid-session aborts the session with no done/fail pulse; the requester must re-request.
- IDLE: if any req bit is high, go to GRANT next cycle.
- GRANT (1 cycle):
  - Pick the winner. With both requesting, the requester not served last wins; otherwise the sole requester wins.
  - Raise gnt and latch that requester's cfg into shadow registers; later cfg changes are ignored.
  - Precheck: llr<=plr<=ulr and ccr!=0. On failure go to FAIL with code 0 and drive no bus activity.
  - On pass go to CRST.
- CRST (1 cycle): cnt_rst_n=0 and cnt_ncs=0. This clears the counter's write locks.
- WRITE, addresses 0,1,2,3 in order:
  - Each access is one strobe cycle (cnt_nwr=0, cnt_oe=1, cnt_a and cnt_dout valid) followed by GAP cycles with cnt_nwr=1.
- READ, addresses 0..3 in order:
  - Each access holds cnt_nrd=0 for 2 cycles and samples cnt_din at the edge closing the second cycle, then GAP idle cycles.
  - On a mismatch against the shadow register, go to FAIL with code 1 right after that access; remaining reads are skipped.
- CHECK (1 cycle): if cnt_err=1, go to FAIL with code 2; else go to START.
- START: cnt_start=1 for exactly 1 cycle, then go to RUN.
- RUN:
  - Run timer starts at 0 and counts up.
  - cnt_ec=1 at a posedge: go to DONE.
  - cnt_err=1: go to FAIL with code 2.
  - Timer reaches TIMEOUT: go to FAIL with code 3.
  - If ec and timeout occur in the same cycle, ec wins.
- DONE / FAIL (1 cycle):
  - Pulse done[g] or fail[g] and present fail_code.
  - Update the RR pointer to g.
  - Drop gnt and return all bus outputs to idle values on the next edge; next state IDLE.
  - If a request is pending, the next GRANT follows IDLE by one cycle.
- Session-wide bus rules:
  - cnt_ncs is 0 from CRST through RUN inclusive and 1 otherwise.
  - cnt_nwr and cnt_nrd are never low together.
  - Every bus output is registered.
- A requester that drops req mid-session does not abort the session; it still receives its pulse.

Decomposition:
- Shared package udc_pkg:
  - register address constants PLR_A=0, ULR_A=1, LLR_A=2, CCR_A=3
  - fail-code constants
  - state enum
  - cfg field slice offsets
- Sub-module udc_rr_arb2: 2-requester round-robin arbiter with a last-winner pointer and an update strobe. Everything else lives in the top FSM.

Test Plan:
- Req0 alone, cfg {ccr=2, llr=10, ulr=20, plr=15}:
  - Bus shows writes 15, 20, 10, 2 at addresses 0..3, then 4 matching reads.
  - One start pulse; model ec after 40 cycles.
  - done[0] pulses exactly once; fail never pulses.
- Req1 with plr=5, llr=10: fail[1] with code 0 two cycles after req; cnt_ncs never drops.
- Both req high from reset: requester 0 served first, then requester 1. Then both again: requester 0 again, because requester 1 was served last.
- Model returns 0xFF on the ULR readback: fail with code 1 after the ULR read; no LLR/CCR reads and no cnt_start.
- Model never asserts ec, TIMEOUT=64: fail with code 3 exactly 64 cycles after cnt_start falls; cnt_ncs returns to 1.
- reset=0 during the WRITE phase: next edge has every output at its reset value; no done/fail pulse; a fresh session restarts from CRST.
